// File: rtl/spu_ls_pkg.sv
// Shared types and widths for the SPU load/store access stage.
// The address helper is shared with instruction fetch.
package spu_ls_pkg;

    localparam int QWORD_W   = 128;
    localparam int ADDR_W    = 32;
    localparam int QSHIFT    = 4;
    localparam int DEF_TAG_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ls_state_t;

    typedef struct packed {
        logic                 is_store;
        logic [ADDR_W-1:0]    ea;
        logic [QWORD_W-1:0]   data;
        logic [DEF_TAG_W-1:0] tag;
    } ls_req_t;

endpackage

// File: rtl/spu_ea_calc.sv
// Effective address calculation: wrapping add, quadword alignment and
// local-store range check. Purely combinational.
module spu_ea_calc
    import spu_ls_pkg::*;
#(
    parameter int LS_QWORDS = 2000
) (
    input  logic [ADDR_W-1:0]        i_base,
    input  logic [ADDR_W-1:0]        i_offset,
    output logic [ADDR_W-1:0]        o_ea,
    output logic [ADDR_W-QSHIFT-1:0] o_qidx,
    output logic                     o_err
);

    localparam logic [ADDR_W-1:0]        ALIGN_MASK = ~ADDR_W'((1 << QSHIFT) - 1);
    localparam logic [ADDR_W-QSHIFT-1:0] QIDX_LIMIT = (ADDR_W-QSHIFT)'(LS_QWORDS);

    logic [ADDR_W-1:0] w_sum;

    // Carry out of the add is intentionally dropped so addresses wrap.
    assign w_sum  = i_base + i_offset;
    assign o_ea   = w_sum & ALIGN_MASK;
    assign o_qidx = w_sum[ADDR_W-1:QSHIFT];
    assign o_err  = (o_qidx >= QIDX_LIMIT);

endmodule

// File: rtl/spu_ls_access.sv
// Load/store access stage feeding the quadword local store: one request at a
// time, single-cycle memory strobes, tagged response with backpressure.
module spu_ls_access
    import spu_ls_pkg::*;
#(
    parameter int LS_QWORDS = 2000,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_store,
    input  logic [31:0]        req_base,
    input  logic [31:0]        req_offset,
    input  logic [127:0]       req_data,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [127:0]       resp_data,
    output logic               resp_is_store,
    output logic               resp_err,
    output logic [15:0]        err_count,
    output logic [31:0]        mem_address,
    output logic [127:0]       mem_writeData,
    output logic               mem_write,
    output logic               mem_read,
    input  logic [127:0]       mem_readData
);

    ls_state_t            r_state;
    ls_state_t            w_next;
    ls_req_t              r_req;
    logic                 r_err;
    logic [15:0]          r_err_count;
    logic [TAG_W-1:0]     r_resp_tag;
    logic [QWORD_W-1:0]   r_resp_data;
    logic                 r_resp_is_store;
    logic                 r_resp_err;

    logic [ADDR_W-1:0]        w_ea;
    logic [ADDR_W-QSHIFT-1:0] w_qidx;
    logic                     w_err;
    logic                     w_unused_qidx;

    spu_ea_calc #(
        .LS_QWORDS (LS_QWORDS)
    ) u_ea_calc (
        .i_base   (req_base),
        .i_offset (req_offset),
        .o_ea     (w_ea),
        .o_qidx   (w_qidx),
        .o_err    (w_err)
    );

    // The index is only needed by fetch; here the aligned ea carries it.
    assign w_unused_qidx = ^w_qidx;

    // Strobes come from the state register so reset kills them asynchronously.
    always_comb begin
        w_next    = r_state;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) w_next = ISSUE;
            end
            ISSUE: begin
                mem_write = r_req.is_store & ~r_err;
                mem_read  = ~r_req.is_store & ~r_err;
                w_next    = (!r_req.is_store && !r_err) ? WAIT : RESP;
            end
            WAIT: begin
                w_next = RESP;
            end
            RESP: begin
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req           <= '0;
            r_err           <= 1'b0;
            r_err_count     <= '0;
            r_resp_tag      <= '0;
            r_resp_data     <= '0;
            r_resp_is_store <= 1'b0;
            r_resp_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req.is_store <= req_is_store;
                        r_req.ea       <= w_ea;
                        r_req.data     <= req_data;
                        r_req.tag      <= DEF_TAG_W'(req_tag);
                        r_err          <= w_err;
                    end
                end
                ISSUE: begin
                    if (r_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                    r_resp_tag      <= TAG_W'(r_req.tag);
                    r_resp_is_store <= r_req.is_store;
                    r_resp_err      <= r_err;
                    r_resp_data     <= '0;
                end
                WAIT: begin
                    // Read data is only valid in this one cycle after the strobe.
                    r_resp_data <= mem_readData;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE) & ~rst;
    assign resp_valid    = (r_state == RESP);
    assign resp_tag      = r_resp_tag;
    assign resp_data     = r_resp_data;
    assign resp_is_store = r_resp_is_store;
    assign resp_err      = r_resp_err;
    assign err_count     = r_err_count;
    assign mem_address   = r_req.ea;
    assign mem_writeData = r_req.data;

endmodule
